// File: rtl/acc_store_unit.sv
// rtl/acc_store_unit.sv - stores the accumulator to data memory over a wr/ack handshake with timeout
// Optional one-entry pending store slot: define ACC_STORE_PENDING_EN.
module acc_store_unit #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] acc_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  input  logic              mem_ack
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
`ifdef ACC_STORE_PENDING_EN
  localparam logic [1:0] ST_GAP   = 2'd2;
`endif

  localparam int                CNT_W     = 8;
  localparam logic [CNT_W-1:0]  CNT_SAT   = '1;
  // Count of no-ack edges at which the next no-ack edge aborts the write.
  localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(MAX_WAIT - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              finish;

`ifdef ACC_STORE_PENDING_EN
  logic              slot_vld_q, slot_vld_d;
  logic [ADDR_W-1:0] slot_addr_q, slot_addr_d;
  logic [DATA_W-1:0] slot_data_q, slot_data_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    finish  = 1'b0;
`ifdef ACC_STORE_PENDING_EN
    slot_vld_d  = slot_vld_q;
    slot_addr_d = slot_addr_q;
    slot_data_d = slot_data_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (st_req) begin
          addr_d  = st_addr;
          wdata_d = acc_in;
          wr_d    = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_WRITE;
        end
      end

      ST_WRITE: begin
        // Ack takes priority over a timeout landing on the same edge.
        if (mem_ack) begin
          done_d = 1'b1;
          finish = 1'b1;
        end else if (cnt_q == WAIT_LAST) begin
          err_d  = 1'b1;
          finish = 1'b1;
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + 1'b1;
        end

`ifdef ACC_STORE_PENDING_EN
        if (st_req && !slot_vld_q) begin
          slot_vld_d  = 1'b1;
          slot_addr_d = st_addr;
          slot_data_d = acc_in;
        end
`endif

        if (finish) begin
          wr_d  = 1'b0;
          cnt_d = '0;
`ifdef ACC_STORE_PENDING_EN
          busy_d  = slot_vld_d;
          state_d = slot_vld_d ? ST_GAP : ST_IDLE;
`else
          busy_d  = 1'b0;
          state_d = ST_IDLE;
`endif
        end
      end

`ifdef ACC_STORE_PENDING_EN
      // One cycle with mem_wr low between back-to-back stores, then issue the slot.
      ST_GAP: begin
        addr_d      = slot_addr_q;
        wdata_d     = slot_data_q;
        wr_d        = 1'b1;
        busy_d      = 1'b1;
        cnt_d       = '0;
        slot_vld_d  = 1'b0;
        state_d     = ST_WRITE;
      end
`endif

      default: begin
        state_d = ST_IDLE;
        wr_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

`ifdef ACC_STORE_PENDING_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_vld_q  <= 1'b0;
      slot_addr_q <= '0;
      slot_data_q <= '0;
    end else begin
      slot_vld_q  <= slot_vld_d;
      slot_addr_q <= slot_addr_d;
      slot_data_q <= slot_data_d;
    end
  end
`endif

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wr    = wr_q;

endmodule

// File: tb/tb_acc_store_unit.sv
// tb/tb_acc_store_unit.sv - directed and randomized self-checking bench for acc_store_unit
module tb_acc_store_unit;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 5;
  localparam int MAX_WAIT = 15;

  logic              clk;
  logic              rst;
  logic              st_req;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] acc_in;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wr;
  logic              mem_ack;

  int errors = 0;
  int checks = 0;
  bit slot_full = 0;

  acc_store_unit #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .st_req    (st_req),
    .st_addr   (st_addr),
    .acc_in    (acc_in),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wr    (mem_wr),
    .mem_ack   (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a store request for one edge; returns in the first mem_wr cycle.
  task automatic issue(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    st_req  = 1'b1;
    st_addr = a;
    acc_in  = d;
    @(posedge clk); #1;
    st_req  = 1'b0;
  endtask

  // Reference: memory acks in mem_wr cycle ack_at (1-based); outside 1..MAX_WAIT means never.
  // The write lasts min(ack_at, MAX_WAIT) cycles and ends in done iff the ack came in time.
  task automatic run_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           input int ack_at, input bit inject);
    bit acked;
    int len;
    acked = (ack_at >= 1) && (ack_at <= MAX_WAIT);
    len   = acked ? ack_at : MAX_WAIT;
    for (int i = 1; i <= len; i++) begin
      chk("wr_mem_wr", mem_wr, 1);
      chk("wr_busy", busy, 1);
      chk("wr_addr", mem_addr, a);
      chk("wr_wdata", mem_wdata, d);
      chk("wr_done", done, 0);
      chk("wr_err", err, 0);
      mem_ack = (i == ack_at);
      if (inject && i == 2) begin
        st_req  = 1'b1;
        st_addr = 5'h02;
        acc_in  = 8'h55;
`ifdef ACC_STORE_PENDING_EN
        slot_full = 1'b1;
`endif
      end
      @(posedge clk); #1;
      st_req  = 1'b0;
      mem_ack = 1'b0;
    end
    chk("end_mem_wr", mem_wr, 0);
    chk("end_busy", busy, slot_full);
    chk("end_done", done, acked);
    chk("end_err", err, !acked);
  endtask

  // Idle cycles with random mem_ack noise, which must be ignored.
  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      mem_ack = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      mem_ack = 1'b0;
      chk("idle_mem_wr", mem_wr, 0);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_err", err, 0);
    end
  endtask

  initial begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    int                rk;
    bit                b2b;

    rst = 1'b0; st_req = 1'b0; st_addr = '0; acc_in = '0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    rst = 1'b1;
    idle_check(2);

    issue(5'h0A, 8'h3C);
    run_write(5'h0A, 8'h3C, 3, 1'b0);
    idle_check(2);

    issue(5'h11, 8'hA5);
    run_write(5'h11, 8'hA5, 1, 1'b0);
    issue(5'h1F, 8'hFF);
    run_write(5'h1F, 8'hFF, 2, 1'b0);
    idle_check(1);

    issue(5'h07, 8'h81);
    run_write(5'h07, 8'h81, 0, 1'b0);
    idle_check(3);

    issue(5'h15, 8'h42);
    run_write(5'h15, 8'h42, MAX_WAIT, 1'b0);
    idle_check(1);

    issue(5'h0A, 8'h3C);
    run_write(5'h0A, 8'h3C, 3, 1'b1);
`ifdef ACC_STORE_PENDING_EN
    slot_full = 1'b0;
    @(posedge clk); #1;
    run_write(5'h02, 8'h55, 1, 1'b0);
`endif
    idle_check(3);

    b2b = 1'b0;
    for (int t = 0; t < 24; t++) begin
      ra = ADDR_W'($urandom);
      rd = DATA_W'($urandom);
      rk = $urandom_range(1, MAX_WAIT + 4);
      if (!b2b) idle_check($urandom_range(1, 3));
      issue(ra, rd);
      run_write(ra, rd, rk, 1'b0);
      b2b = 1'($urandom_range(0, 1));
    end
    idle_check(1);

    issue(5'h0C, 8'h99);
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_mem_wr", mem_wr, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_mem_wr", mem_wr, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_addr", mem_addr, 0);
    chk("async_rst_wdata", mem_wdata, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_err", err, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    slot_full = 1'b0;
    idle_check(MAX_WAIT + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
